clk_div_monitor: RTL and testbench

- Consumer-side counterpart to the matrix clock divider.
- Samples the divided clock in the fast system clock domain through a synchronizer and emits a single-cycle tick on each of its rising edges.
- Measures the divided-clock period and reports lock or loss against the expected division ratio.
- Matrix datapath logic uses tick as a clock enable and never clocks directly off the divided signal.

---
 rtl/clk_div_monitor.sv | 160 ++++++++++++++++
 tb/tb_clk_div_monitor.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: synchronizes clk_div_in into the clk domain, emits a tick
// per rising edge, measures the period and tracks lock against the expected ratio.
module clk_div_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_BIT     = 13,
  parameter int TOL         = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_div_in,
  output logic                 tick,
  output logic                 locked,
  output logic [DIV_BIT+2:0]   period,
  output logic                 period_err
);

  localparam int PW    = DIV_BIT + 3;
  localparam int LIM_W = PW + 1;
  localparam int EXP   = 1 << (DIV_BIT + 1);
  localparam int GW    = $clog2(LOCK_COUNT + 1);

  localparam logic [LIM_W-1:0] LO_LIM = LIM_W'(EXP - TOL);
  localparam logic [LIM_W-1:0] HI_LIM = LIM_W'(EXP + TOL);
  localparam logic [PW-1:0]    TMO    = PW'(EXP + TOL);
  localparam logic [GW-1:0]    LOCK_N = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   tick_reg;
  logic                   s;
  logic                   rise;

  logic [PW-1:0]          cnt_reg;
  logic [PW-1:0]          period_reg;
  logic [LIM_W-1:0]       cnt_inc;
  logic                   cnt_sat;
  logic                   in_tol;
  logic                   timeout_hit;

  state_t                 state_reg;
  state_t                 state_next;
  logic [GW-1:0]          good_cnt_reg;
  logic [GW-1:0]          good_cnt_next;
  logic [GW-1:0]          good_cnt_inc;
  logic                   err_reg;
  logic                   err_next;
  logic                   locked_reg;

  assign s    = sync_reg[SYNC_STAGES-1];
  assign rise = s & ~prev_reg;

  // clk_div_in is asynchronous to clk; only the last stage is ever used by logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], clk_div_in};
      prev_reg <= s;
      tick_reg <= rise;
    end
  end

  // One extra bit so cnt+1 at saturation never wraps into the tolerance window.
  assign cnt_inc     = {1'b0, cnt_reg} + LIM_W'(1);
  assign cnt_sat     = &cnt_reg;
  assign in_tol      = (cnt_inc >= LO_LIM) && (cnt_inc <= HI_LIM);
  assign timeout_hit = (cnt_reg == TMO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      period_reg <= '0;
    end else if (rise) begin
      cnt_reg    <= '0;
      period_reg <= cnt_inc[PW] ? '1 : cnt_inc[PW-1:0];
    end else if (!cnt_sat) begin
      cnt_reg    <= cnt_inc[PW-1:0];
    end
  end

  assign good_cnt_inc = good_cnt_reg + GW'(1);

  always_comb begin
    state_next    = state_reg;
    good_cnt_next = good_cnt_reg;
    err_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        // The first period after idle is measured from an unknown start point.
        if (rise) begin
          state_next    = ACQ;
          good_cnt_next = '0;
        end
      end
      ACQ: begin
        if (rise) begin
          if (in_tol) begin
            good_cnt_next = good_cnt_inc;
            if (good_cnt_inc == LOCK_N) begin
              state_next = LOCKED;
            end
          end else begin
            good_cnt_next = '0;
            err_next      = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next    = IDLE;
          good_cnt_next = '0;
          err_next      = 1'b1;
        end
      end
      LOCKED: begin
        if (rise) begin
          if (!in_tol) begin
            state_next    = ACQ;
            good_cnt_next = '0;
            err_next      = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next    = IDLE;
          good_cnt_next = '0;
          err_next      = 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        good_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      good_cnt_reg <= '0;
      err_reg      <= 1'b0;
      locked_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      good_cnt_reg <= good_cnt_next;
      err_reg      <= err_next;
      locked_reg   <= (state_reg == LOCKED);
    end
  end

  assign tick       = tick_reg;
  assign locked     = locked_reg;
  assign period     = period_reg;
  assign period_err = err_reg;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: drives period/duty sequences and compares every cycle
// against an event-level model built on tick-to-tick gaps.
module tb_clk_div_monitor;

  localparam int SYNC_STAGES = 2;
  localparam int DIV_BIT     = 2;
  localparam int TOL         = 1;
  localparam int LOCK_COUNT  = 3;
  localparam int PW          = DIV_BIT + 3;
  localparam int EXP         = 1 << (DIV_BIT + 1);
  localparam int PMAX        = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_div_in = 1'b0;
  logic          tick;
  logic          locked;
  logic [PW-1:0] period;
  logic          period_err;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .SYNC_STAGES(SYNC_STAGES),
    .DIV_BIT    (DIV_BIT),
    .TOL        (TOL),
    .LOCK_COUNT (LOCK_COUNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_div_in(clk_div_in),
    .tick      (tick),
    .locked    (locked),
    .period    (period),
    .period_err(period_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: edge index n counts clk edges since reset release.
  int            n;
  bit            samp_q[$];
  int            last_tick;
  int            mode;        // 0 idle, 1 acquiring, 2 locked
  int            good;
  bit            exp_tick;
  bit            exp_locked;
  bit            exp_err;
  logic [PW-1:0] exp_period;
  bit            stim[$];

  function automatic bit samp_at(input int e);
    if (e < 1 || e > samp_q.size()) return 1'b0;
    return samp_q[e-1];
  endfunction

  function automatic void model_reset();
    n          = 0;
    samp_q.delete();
    last_tick  = 0;
    mode       = 0;
    good       = 0;
    exp_tick   = 1'b0;
    exp_locked = 1'b0;
    exp_err    = 1'b0;
    exp_period = '0;
  endfunction

  function automatic void push_period(input int p, input int h);
    for (int i = 0; i < p; i++) stim.push_back(i < h);
  endfunction

  function automatic void push_level(input int len, input bit v);
    for (int i = 0; i < len; i++) stim.push_back(v);
  endfunction

  // Drive one sample, advance the model by one clk edge, return at the falling edge.
  task automatic step(input bit v);
    bit was_lock;
    bit in_win;
    int gap;
    clk_div_in = v;
    @(posedge clk);
    n++;
    samp_q.push_back(v);
    was_lock = (mode == 2);
    exp_tick = samp_at(n - SYNC_STAGES) && !samp_at(n - SYNC_STAGES - 1);
    exp_err  = 1'b0;
    if (exp_tick) begin
      gap        = n - last_tick;
      last_tick  = n;
      exp_period = (gap > PMAX) ? PW'(PMAX) : PW'(gap);
      in_win     = (gap >= EXP - TOL) && (gap <= EXP + TOL);
      if (mode == 0) begin
        mode = 1;
        good = 0;
      end else if (mode == 1) begin
        if (in_win) begin
          good++;
          if (good == LOCK_COUNT) mode = 2;
        end else begin
          good    = 0;
          exp_err = 1'b1;
        end
      end else if (!in_win) begin
        mode    = 1;
        good    = 0;
        exp_err = 1'b1;
      end
    end else if (mode != 0 && (n - last_tick) == EXP + TOL + 1) begin
      mode    = 0;
      good    = 0;
      exp_err = 1'b1;
    end
    exp_locked = was_lock;
    @(negedge clk);
    if (tick === 1'b1)
      $display("tick n=%0d period=%0d locked=%b period_err=%b", n, period, locked, period_err);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tick, locked, period_err, period} !== '0) begin
      errors++;
      $display("FAIL reset_state got t/l/e/p=%b/%b/%b/%0d want 0/0/0/0", tick, locked, period_err, period);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_lock_square();
    int first_tick = -1;
    int errs_seen  = 0;
    stim.delete();
    push_level(3, 1'b0);
    for (int k = 0; k < 6; k++) push_period(8, 4);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      if (tick === 1'b1 && first_tick < 0) first_tick = n;
      if (period_err === 1'b1) errs_seen++;
      checks++;
      if ({tick, locked, period_err, period} !== {exp_tick, exp_locked, exp_err, exp_period}) begin
        errors++;
        $display("FAIL square n=%0d got t/l/e/p=%b/%b/%b/%0d want %b/%b/%b/%0d", n, tick, locked, period_err, period, exp_tick, exp_locked, exp_err, exp_period);
      end
    end
    checks++;
    if (first_tick != 4 + SYNC_STAGES) begin
      errors++;
      $display("FAIL first_tick_latency got edge %0d want edge %0d", first_tick, 4 + SYNC_STAGES);
    end
    checks++;
    if (errs_seen != 0 || locked !== 1'b1 || period !== PW'(8)) begin
      errors++;
      $display("FAIL square_summary got errs=%0d locked=%b period=%0d want 0/1/8", errs_seen, locked, period);
    end
  endtask

  task automatic test_lost_period();
    int errs_seen = 0;
    stim.delete();
    push_period(10, 5);
    for (int k = 0; k < 4; k++) push_period(8, 4);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      if (period_err === 1'b1) errs_seen++;
      checks++;
      if ({tick, locked, period_err, period} !== {exp_tick, exp_locked, exp_err, exp_period}) begin
        errors++;
        $display("FAIL lost_period n=%0d got t/l/e/p=%b/%b/%b/%0d want %b/%b/%b/%0d", n, tick, locked, period_err, period, exp_tick, exp_locked, exp_err, exp_period);
      end
    end
    checks++;
    if (errs_seen != 1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL lost_period_summary got errs=%0d locked=%b want 1/1", errs_seen, locked);
    end
  endtask

  task automatic test_boundary();
    int errs_seen = 0;
    int p;
    stim.delete();
    for (int k = 0; k < 6; k++) begin
      p = 7 + int'($urandom_range(0, 2));
      push_period(p, int'($urandom_range(1, p - 1)));
    end
    push_period(6, 3);
    for (int k = 0; k < 4; k++) push_period(8, 4);
    push_period(10, int'($urandom_range(1, 9)));
    for (int k = 0; k < 4; k++) push_period(8, 4);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      if (period_err === 1'b1) errs_seen++;
      checks++;
      if ({tick, locked, period_err, period} !== {exp_tick, exp_locked, exp_err, exp_period}) begin
        errors++;
        $display("FAIL boundary n=%0d got t/l/e/p=%b/%b/%b/%0d want %b/%b/%b/%0d", n, tick, locked, period_err, period, exp_tick, exp_locked, exp_err, exp_period);
      end
    end
    checks++;
    if (errs_seen != 2 || locked !== 1'b1) begin
      errors++;
      $display("FAIL boundary_summary got errs=%0d locked=%b want 2/1", errs_seen, locked);
    end
  endtask

  task automatic test_stuck_low();
    int errs_stuck = 0;
    int seg;
    bit lock_after;
    stim.delete();
    push_level(14, 1'b0);
    seg = stim.size();
    for (int k = 0; k < 5; k++) push_period(8, 4);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      if (i < seg && period_err === 1'b1) errs_stuck++;
      if (i == seg - 1) lock_after = locked;
      checks++;
      if ({tick, locked, period_err, period} !== {exp_tick, exp_locked, exp_err, exp_period}) begin
        errors++;
        $display("FAIL stuck_low n=%0d got t/l/e/p=%b/%b/%b/%0d want %b/%b/%b/%0d", n, tick, locked, period_err, period, exp_tick, exp_locked, exp_err, exp_period);
      end
    end
    checks++;
    if (errs_stuck != 1 || lock_after !== 1'b0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL stuck_low_summary got errs=%0d locked_stuck=%b locked_end=%b want 1/0/1", errs_stuck, lock_after, locked);
    end
  endtask

  task automatic test_async_reset();
    stim.delete();
    push_period(8, 4);
    push_period(8, 4);
    push_level(2, 1'b1);
    for (int i = 0; i < stim.size(); i++) step(stim[i]);
    checks++;
    if (locked !== 1'b1 || period !== PW'(8)) begin
      errors++;
      $display("FAIL pre_reset got locked=%b period=%0d want 1/8", locked, period);
    end
    clk_div_in = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({tick, locked, period_err, period} !== '0) begin
      errors++;
      $display("FAIL async_reset got t/l/e/p=%b/%b/%b/%0d want 0/0/0/0", tick, locked, period_err, period);
    end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    stim.delete();
    push_level(12, 1'b1);
    push_level(4, 1'b0);
    for (int k = 0; k < 5; k++) push_period(8, 4);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      checks++;
      if ({tick, locked, period_err, period} !== {exp_tick, exp_locked, exp_err, exp_period}) begin
        errors++;
        $display("FAIL post_reset n=%0d got t/l/e/p=%b/%b/%b/%0d want %b/%b/%b/%0d", n, tick, locked, period_err, period, exp_tick, exp_locked, exp_err, exp_period);
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_relock got locked=%b want 1", locked);
    end
  endtask

  task automatic test_low_duty();
    int first_tick = -1;
    int errs_seen  = 0;
    clk_div_in = 1'b0;
    do_reset();
    stim.delete();
    push_level(3, 1'b0);
    for (int k = 0; k < 6; k++) push_period(8, 1);
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      if (tick === 1'b1 && first_tick < 0) first_tick = n;
      if (period_err === 1'b1) errs_seen++;
      checks++;
      if ({tick, locked, period_err, period} !== {exp_tick, exp_locked, exp_err, exp_period}) begin
        errors++;
        $display("FAIL low_duty n=%0d got t/l/e/p=%b/%b/%b/%0d want %b/%b/%b/%0d", n, tick, locked, period_err, period, exp_tick, exp_locked, exp_err, exp_period);
      end
    end
    checks++;
    if (first_tick != 4 + SYNC_STAGES || errs_seen != 0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL low_duty_summary got first=%0d errs=%0d locked=%b want %0d/0/1", first_tick, errs_seen, locked, 4 + SYNC_STAGES);
    end
  endtask

  task automatic test_random();
    int p;
    stim.delete();
    for (int k = 0; k < 40; k++) begin
      p = int'($urandom_range(5, 12));
      push_period(p, int'($urandom_range(1, p - 1)));
    end
    for (int i = 0; i < stim.size(); i++) begin
      step(stim[i]);
      checks++;
      if ({tick, locked, period_err, period} !== {exp_tick, exp_locked, exp_err, exp_period}) begin
        errors++;
        $display("FAIL random n=%0d got t/l/e/p=%b/%b/%b/%0d want %b/%b/%b/%0d", n, tick, locked, period_err, period, exp_tick, exp_locked, exp_err, exp_period);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_square();
    test_lost_period();
    test_boundary();
    test_stuck_low();
    test_async_reset();
    test_low_duty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
